systolic_seq: RTL and testbench

Sequencer for the 2x2 systolic multiplier (`systolic`). It accepts a serial stream of eight 4-bit operands and assembles matrices A and B. It then fires the array with a single `in_val` pulse, waits for `out_val`, captures the four 9-bit products and returns them as a serial result stream. It sits between the operand/result FIFOs and the array and owns the array's input handshake.

---
 rtl/systolic_seq.sv | 167 ++++++++++++++++
 tb/tb_systolic_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq.sv
// systolic_seq: loads 8 serial operands, fires the 2x2 systolic array once, streams back its 4 products.
// Latency: array fired the cycle after the 8th operand; first result valid the cycle after arr_out_val.
// Backpressure: op_rdy only in LOAD, res_data held until res_rdy; WAIT abort via SYSTOLIC_SEQ_TIMEOUT_EN.
module systolic_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_val,
  input  logic [3:0]  op_data,
  output logic        op_rdy,
  output logic        arr_in_val,
  output logic [15:0] arr_a,
  output logic [15:0] arr_b,
  input  logic        arr_out_val,
  input  logic [35:0] arr_c,
  output logic        res_val,
  output logic [8:0]  res_data,
  output logic        res_last,
  input  logic        res_rdy,
  output logic        busy,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FIRE  = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  // Operand slots in arrival order: a11,a12,a21,a22,b11,b12,b21,b22.
  logic [7:0][3:0] r_ops;
  logic [2:0]      r_ld_cnt;
  // Captured products, slot 0 is c11.
  logic [3:0][8:0] r_c;
  logic [1:0]      r_rd_cnt;

  logic            w_op_hs;
  logic            w_res_hs;
  logic            w_capture;
  logic            w_expire;

  assign w_op_hs   = (r_state == S_LOAD)  && op_val;
  assign w_res_hs  = (r_state == S_DRAIN) && res_rdy;
  assign w_capture = (r_state == S_WAIT)  && arr_out_val;

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);

  logic [WCW-1:0] r_wait_cnt;
  logic [WCW-1:0] w_wait_inc;
  logic           r_err;

  assign w_wait_inc = r_wait_cnt + WCW'(1);
  // A result arriving on the expiry cycle takes priority over the abort.
  assign w_expire   = (r_state == S_WAIT) && !arr_out_val && (w_wait_inc == WCW'(TIMEOUT));

  // WAIT cycle counter, zeroed while firing so it reads 0 on the first WAIT cycle; abort pulse register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_expire;
      if (r_state == S_FIRE) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= w_wait_inc;
      end
    end
  end

  assign err_timeout = r_err;
`else
  // Without the abort feature WAIT simply holds until the array answers.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT >= 1);
  assign w_expire         = 1'b0;
  assign err_timeout      = 1'b0;
`endif

  // State register; reset from any state returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode for the single-transaction sequence.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_LOAD;
      S_LOAD:  if (w_op_hs && (r_ld_cnt == 3'd7)) w_state_nxt = S_FIRE;
      S_FIRE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (arr_out_val) begin
          w_state_nxt = S_DRAIN;
        end else if (w_expire) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DRAIN: if (w_res_hs && (r_rd_cnt == 2'd3)) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand slots, load/drain counters and the captured product register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ops    <= '0;
      r_ld_cnt <= 3'd0;
      r_c      <= '0;
      r_rd_cnt <= 2'd0;
    end else begin
      if (w_op_hs) begin
        r_ops[r_ld_cnt] <= op_data;
        r_ld_cnt        <= r_ld_cnt + 3'd1;
      end
      if (w_capture) begin
        r_c <= arr_c;
      end
      if (w_res_hs) begin
        r_rd_cnt <= r_rd_cnt + 2'd1;
      end
    end
  end

  // Outputs decoded from registered state only, so no input reaches an output combinationally.
  always_comb begin
    op_rdy     = 1'b0;
    arr_in_val = 1'b0;
    res_val    = 1'b0;
    res_last   = 1'b0;
    res_data   = 9'd0;
    busy       = 1'b0;
    unique case (r_state)
      S_LOAD: op_rdy = 1'b1;
      S_FIRE: begin
        arr_in_val = 1'b1;
        busy       = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_DRAIN: begin
        busy     = 1'b1;
        res_val  = 1'b1;
        res_data = r_c[r_rd_cnt];
        res_last = (r_rd_cnt == 2'd3);
      end
      default: begin
        op_rdy = 1'b0;
      end
    endcase
  end

  // Matrix operands are straight from the slot registers and hold until the next load overwrites them.
  assign arr_a = r_ops[3:0];
  assign arr_b = r_ops[7:4];

endmodule

// File: tb/tb_systolic_seq.sv
// tb_systolic_seq: directed checks of the systolic sequencer against a behavioural 2x2 array.
// Latency: array model answers ARR_LAT cycles after seeing arr_in_val.
// Backpressure: res_rdy stalled in one case; op_val gaps in another.
module tb_systolic_seq;

  localparam int          ARR_LAT = 3;
  localparam logic [31:0] OPS1    = 32'h87654321;
  localparam logic [31:0] OPS2    = 32'hFFFFFFFF;
  localparam logic [35:0] EXP1    = {9'd50, 9'd43, 9'd22, 9'd19};
  localparam logic [35:0] EXP2    = {9'd450, 9'd450, 9'd450, 9'd450};

  logic        clk;
  logic        rst_n;
  logic        op_val;
  logic [3:0]  op_data;
  logic        op_rdy;
  logic        arr_in_val;
  logic [15:0] arr_a;
  logic [15:0] arr_b;
  logic        arr_out_val;
  logic [35:0] arr_c;
  logic        res_val;
  logic [8:0]  res_data;
  logic        res_last;
  logic        res_rdy;
  logic        busy;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fire  = 0;
  logic arr_en;

  systolic_seq #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_val      (op_val),
    .op_data     (op_data),
    .op_rdy      (op_rdy),
    .arr_in_val  (arr_in_val),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .arr_out_val (arr_out_val),
    .arr_c       (arr_c),
    .res_val     (res_val),
    .res_data    (res_data),
    .res_last    (res_last),
    .res_rdy     (res_rdy),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (arr_in_val === 1'b1) n_fire++;
  end

  function automatic logic [8:0] dot(input logic [3:0] x0, input logic [3:0] y0,
                                     input logic [3:0] x1, input logic [3:0] y1);
    return 9'(x0 * y0) + 9'(x1 * y1);
  endfunction

  // Behavioural 2x2 array: latches operands on in_val, answers ARR_LAT cycles later.
  initial begin
    logic [15:0] a;
    logic [15:0] b;
    arr_out_val = 1'b0;
    arr_c       = '0;
    forever begin
      @(negedge clk);
      if (arr_en && (arr_in_val === 1'b1)) begin
        a = arr_a;
        b = arr_b;
        repeat (ARR_LAT) @(negedge clk);
        arr_c = {dot(a[11:8], b[7:4], a[15:12], b[15:12]),
                 dot(a[11:8], b[3:0], a[15:12], b[11:8]),
                 dot(a[3:0],  b[7:4], a[7:4],   b[15:12]),
                 dot(a[3:0],  b[3:0], a[7:4],   b[11:8])};
        arr_out_val = 1'b1;
        @(negedge clk);
        arr_out_val = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_rdy"},   op_rdy,      0);
    check({tag, "_in_val"},   arr_in_val,  0);
    check({tag, "_res_val"},  res_val,     0);
    check({tag, "_res_last"}, res_last,    0);
    check({tag, "_busy"},     busy,        0);
    check({tag, "_err"},      err_timeout, 0);
    check({tag, "_arr_a"},    arr_a,       0);
    check({tag, "_arr_b"},    arr_b,       0);
    check({tag, "_res_data"}, res_data,    0);
  endtask

  // Hold reset for 'cycles' edges, check reset values, release and expect LOAD one cycle later.
  task automatic do_reset(input string tag, input int cycles);
    rst_n  = 1'b0;
    op_val = 1'b0;
    repeat (cycles) @(negedge clk);
    check_reset_outputs(tag);
    rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_op_rdy_up"}, op_rdy, 1);
    check({tag, "_busy_load"}, busy,   0);
  endtask

  // Sends the 8 nibbles of ops (nibble 0 first) with 'gap' idle cycles between them.
  task automatic send_ops(input logic [31:0] ops, input int gap);
    for (int i = 0; i < 8; i++) begin
      int budget;
      budget  = 0;
      op_val  = 1'b1;
      op_data = ops[i*4 +: 4];
      while ((op_rdy !== 1'b1) && (budget < 40)) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 40) check("op_rdy_timeout", op_rdy, 1);
      @(negedge clk);
      op_val = 1'b0;
      if (i < 7) repeat (gap) @(negedge clk);
    end
  endtask

  // Collects n results, optionally stalling res_rdy on the first one.
  task automatic recv_results(input string tag, input logic [35:0] exp, input int stall, input int n);
    for (int k = 0; k < n; k++) begin
      int budget;
      budget = 0;
      while ((res_val !== 1'b1) && (budget < 60)) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 60) check({tag, "_res_val_timeout"}, res_val, 1);
      check({tag, "_res_data"}, res_data, exp[k*9 +: 9]);
      check({tag, "_res_last"}, res_last, (k == 3) ? 1 : 0);
      check({tag, "_op_rdy_busy"}, op_rdy, 0);
      if ((k == 0) && (stall > 0)) begin
        res_rdy = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          check({tag, "_stall_val"},  res_val,  1);
          check({tag, "_stall_data"}, res_data, exp[8:0]);
          check({tag, "_stall_rdy"},  op_rdy,   0);
        end
        res_rdy = 1'b1;
      end
      @(negedge clk);
    end
    if (n == 4) begin
      check({tag, "_op_rdy_after"},  op_rdy,  1);
      check({tag, "_res_val_after"}, res_val, 0);
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] ops, input logic [35:0] exp,
                          input int gap, input int stall);
    int f0;
    f0 = n_fire;
    send_ops(ops, gap);
    check({tag, "_fire"},  arr_in_val, 1);
    check({tag, "_arr_a"}, arr_a, ops[15:0]);
    check({tag, "_arr_b"}, arr_b, ops[31:16]);
    @(negedge clk);
    check({tag, "_fire_once"}, arr_in_val, 0);
    check({tag, "_busy"},      busy,       1);
    recv_results(tag, exp, stall, 4);
    check({tag, "_fire_count"}, n_fire - f0, 1);
  endtask

  initial begin
    rst_n   = 1'b0;
    op_val  = 1'b0;
    op_data = 4'd0;
    res_rdy = 1'b1;
    arr_en  = 1'b1;
    @(negedge clk);
    do_reset("rst", 2);

    run_case("c1_basic", OPS1, EXP1, 0, 0);
    run_case("c2_max",   OPS2, EXP2, 0, 0);
    run_case("c3_stall", OPS1, EXP1, 0, 5);
    run_case("c4_gaps",  OPS1, EXP1, 3, 0);

    // Reset in the middle of DRAIN, then a clean transaction.
    send_ops(OPS1, 0);
    recv_results("c6_part", EXP1, 0, 2);
    do_reset("c6_rst", 1);
    run_case("c6_clean", OPS1, EXP1, 0, 0);

    // Array never answers.
    arr_en = 1'b0;
    send_ops(OPS1, 0);
    check("c5_fire", arr_in_val, 1);
    @(negedge clk);
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    for (int c = 0; c < 16; c++) begin
      check("c5_wait_err",  err_timeout, 0);
      check("c5_wait_res",  res_val,     0);
      check("c5_wait_busy", busy,        1);
      @(negedge clk);
    end
    check("c5_err_pulse", err_timeout, 1);
    check("c5_err_load",  op_rdy,      1);
    check("c5_err_nores", res_val,     0);
    @(negedge clk);
    check("c5_err_end",   err_timeout, 0);
    check("c5_rdy_after", op_rdy,      1);
`else
    for (int c = 0; c < 24; c++) begin
      check("c5_hold_busy", busy,        1);
      check("c5_hold_err",  err_timeout, 0);
      check("c5_hold_res",  res_val,     0);
      @(negedge clk);
    end
    do_reset("c5_rst", 1);
`endif
    arr_en = 1'b1;
    run_case("c5_recover", OPS2, EXP2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
